iter_alu: RTL and testbench

//  Parametrised sequential ALU: registered single-cycle ops plus iterative multiply/divide.

---
 rtl/iter_alu.sv | 245 ++++++++++++++++++++++++
 tb/tb_iter_alu.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/iter_alu.sv
// Sequential ALU: registered single-cycle ops plus iterative shift-add multiply
// and restoring divide, one bit per cycle, stalling the issuer via in_ready.
module iter_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       ALUOp,
  output logic             out_valid,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] C_hi,
  output logic             Zero,
  output logic             div_by_zero
);

  localparam logic [4:0] OP_ADD  = 5'b00001;
  localparam logic [4:0] OP_SUB  = 5'b00010;
  localparam logic [4:0] OP_AND  = 5'b00011;
  localparam logic [4:0] OP_OR   = 5'b00100;
  localparam logic [4:0] OP_SLT  = 5'b00101;
  localparam logic [4:0] OP_SLTU = 5'b00110;
  localparam logic [4:0] OP_SLL  = 5'b00111;
  localparam logic [4:0] OP_SRL  = 5'b01000;
  localparam logic [4:0] OP_SRA  = 5'b01001;
  localparam logic [4:0] OP_XOR  = 5'b01010;
  localparam logic [4:0] OP_NOR  = 5'b01011;
  localparam logic [4:0] OP_MULU = 5'b01100;
  localparam logic [4:0] OP_MUL  = 5'b01101;
  localparam logic [4:0] OP_DIVU = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;

  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ONES_W = {WIDTH{1'b1}};
  localparam logic [SHW-1:0]   CNT_LAST = SHW'(WIDTH - 1);
  localparam logic [SHW-1:0]   CNT_ONE  = SHW'(1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  function automatic logic [WIDTH-1:0] single_op(input logic [4:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    logic [SHW-1:0]   sh;
    sh = b[SHW-1:0];
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_SLT:  r = ($signed(a) < $signed(b)) ? ONE_W : ZERO_W;
      OP_SLTU: r = (a < b) ? ONE_W : ZERO_W;
      OP_SLL:  r = a << sh;
      OP_SRL:  r = a >> sh;
      OP_SRA:  r = $signed(a) >>> sh;
      OP_XOR:  r = a ^ b;
      OP_NOR:  r = ~(a | b);
      default: r = b;
    endcase
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic is_signed);
    return (is_signed && v[WIDTH-1]) ? -v : v;
  endfunction

  state_t           state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] c_q, c_d, c_hi_q, c_hi_d;
  logic             zero_q, zero_d, dbz_q, dbz_d;
  logic             zero_pend_q, zero_pend_d;
  logic             is_div_q, is_div_d;
  logic             neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
  logic [WIDTH-1:0] acc_q, acc_d, sh_q, sh_d, opnd_q, opnd_d;

  logic [WIDTH:0]     mul_sum_s, rem_sh_s, diff_s;
  logic [WIDTH-1:0]   step_acc_s, step_sh_s, quo_s, rem_s;
  logic [2*WIDTH-1:0] prod_s;
  logic               multi_s, signed_s, b_zero_s;

  // Next-state, iteration step and result formatting
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = 1'b0;
    c_d         = c_q;
    c_hi_d      = c_hi_q;
    zero_d      = zero_q;
    dbz_d       = dbz_q;
    zero_pend_d = zero_pend_q;
    is_div_d    = is_div_q;
    neg_lo_d    = neg_lo_q;
    neg_hi_d    = neg_hi_q;
    acc_d       = acc_q;
    sh_d        = sh_q;
    opnd_d      = opnd_q;
    mul_sum_s   = {(WIDTH+1){1'b0}};
    rem_sh_s    = {(WIDTH+1){1'b0}};
    diff_s      = {(WIDTH+1){1'b0}};

    // acc holds the product high half / partial remainder, sh the low half / quotient
    if (is_div_q) begin
      rem_sh_s = {acc_q, sh_q[WIDTH-1]};
      diff_s   = rem_sh_s - {1'b0, opnd_q};
      if (!diff_s[WIDTH]) begin
        step_acc_s = diff_s[WIDTH-1:0];
        step_sh_s  = {sh_q[WIDTH-2:0], 1'b1};
      end else begin
        step_acc_s = rem_sh_s[WIDTH-1:0];
        step_sh_s  = {sh_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      mul_sum_s  = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
      step_acc_s = mul_sum_s[WIDTH:1];
      step_sh_s  = {mul_sum_s[0], sh_q[WIDTH-1:1]};
    end

    prod_s = {step_acc_s, step_sh_s};
    prod_s = neg_lo_q ? -prod_s : prod_s;
    quo_s  = neg_lo_q ? -step_sh_s : step_sh_s;
    rem_s  = neg_hi_q ? -step_acc_s : step_acc_s;

    multi_s  = (ALUOp == OP_MUL) || (ALUOp == OP_MULU) ||
               (ALUOp == OP_DIV) || (ALUOp == OP_DIVU);
    signed_s = (ALUOp == OP_MUL) || (ALUOp == OP_DIV);
    b_zero_s = (B == ZERO_W);

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          if (multi_s && !((ALUOp == OP_DIV || ALUOp == OP_DIVU) && b_zero_s)) begin
            state_d     = BUSY;
            in_ready_d  = 1'b0;
            cnt_d       = {SHW{1'b0}};
            zero_pend_d = (A == B);
            is_div_d    = (ALUOp == OP_DIV) || (ALUOp == OP_DIVU);
            neg_lo_d    = signed_s && (A[WIDTH-1] ^ B[WIDTH-1]);
            neg_hi_d    = (ALUOp == OP_DIV) ? A[WIDTH-1] : neg_lo_d;
            acc_d       = ZERO_W;
            if (is_div_d) begin
              sh_d   = magnitude(A, signed_s);
              opnd_d = magnitude(B, signed_s);
            end else begin
              sh_d   = magnitude(B, signed_s);
              opnd_d = magnitude(A, signed_s);
            end
          end else if (multi_s) begin
            c_d         = ONES_W;
            c_hi_d      = A;
            zero_d      = (A == B);
            dbz_d       = 1'b1;
            out_valid_d = 1'b1;
          end else begin
            c_d         = single_op(ALUOp, A, B);
            c_hi_d      = ZERO_W;
            zero_d      = (A == B);
            dbz_d       = 1'b0;
            out_valid_d = 1'b1;
          end
        end else begin
          out_valid_d = 1'b0;
        end
      end
      BUSY: begin
        if (cnt_q == CNT_LAST) begin
          state_d     = IDLE;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b1;
          cnt_d       = {SHW{1'b0}};
          zero_d      = zero_pend_q;
          dbz_d       = 1'b0;
          if (is_div_q) begin
            c_d    = quo_s;
            c_hi_d = rem_s;
          end else begin
            c_d    = prod_s[WIDTH-1:0];
            c_hi_d = prod_s[2*WIDTH-1:WIDTH];
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
          acc_d = step_acc_s;
          sh_d  = step_sh_s;
        end
      end
      default: begin
        state_d    = IDLE;
        in_ready_d = 1'b1;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= {SHW{1'b0}};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      c_q         <= ZERO_W;
      c_hi_q      <= ZERO_W;
      zero_q      <= 1'b0;
      dbz_q       <= 1'b0;
      zero_pend_q <= 1'b0;
      is_div_q    <= 1'b0;
      neg_lo_q    <= 1'b0;
      neg_hi_q    <= 1'b0;
      acc_q       <= ZERO_W;
      sh_q        <= ZERO_W;
      opnd_q      <= ZERO_W;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      c_q         <= c_d;
      c_hi_q      <= c_hi_d;
      zero_q      <= zero_d;
      dbz_q       <= dbz_d;
      zero_pend_q <= zero_pend_d;
      is_div_q    <= is_div_d;
      neg_lo_q    <= neg_lo_d;
      neg_hi_q    <= neg_hi_d;
      acc_q       <= acc_d;
      sh_q        <= sh_d;
      opnd_q      <= opnd_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign C           = c_q;
  assign C_hi        = c_hi_q;
  assign Zero        = zero_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_iter_alu.sv
// Directed bench for iter_alu at WIDTH=32: hand-computed results, latency,
// in_ready stall length, divide-by-zero and mid-operation reset.
module tb_iter_alu;

  localparam logic [4:0] OP_ADD  = 5'b00001;
  localparam logic [4:0] OP_SUB  = 5'b00010;
  localparam logic [4:0] OP_OR   = 5'b00100;
  localparam logic [4:0] OP_SLT  = 5'b00101;
  localparam logic [4:0] OP_SLTU = 5'b00110;
  localparam logic [4:0] OP_SLL  = 5'b00111;
  localparam logic [4:0] OP_SRL  = 5'b01000;
  localparam logic [4:0] OP_SRA  = 5'b01001;
  localparam logic [4:0] OP_XOR  = 5'b01010;
  localparam logic [4:0] OP_NOR  = 5'b01011;
  localparam logic [4:0] OP_MULU = 5'b01100;
  localparam logic [4:0] OP_MUL  = 5'b01101;
  localparam logic [4:0] OP_DIVU = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, Zero, div_by_zero;
  logic [31:0] A, B, C, C_hi;
  logic [4:0]  ALUOp;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          lat, busy, pulses;

  iter_alu #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .ALUOp(ALUOp), .out_valid(out_valid),
    .C(C), .C_hi(C_hi), .Zero(Zero), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one op at the current negedge, then wait (bounded) for out_valid.
  // Operands are scrambled after the accept edge to prove they were captured.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int n_lat, output int n_busy);
    in_valid = 1'b1; ALUOp = op; A = a; B = b;
    n_lat = 0; n_busy = 0;
    do begin
      @(negedge clk);
      n_lat++;
      in_valid = 1'b0; A = $urandom; B = $urandom;
      if (!in_ready) n_busy++;
    end while (!out_valid && n_lat < 100);
  endtask

  task automatic check_single(input string tag, input logic [4:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] exp_c, input logic exp_z);
    int l, bz;
    run_op(op, a, b, l, bz);
    check_eq({tag, "_lat"}, 64'(l), 64'd1);
    check_eq({tag, "_c"}, {C_hi, C}, {32'h0, exp_c});
    check_eq({tag, "_zero"}, {63'd0, Zero}, {63'd0, exp_z});
  endtask

  task automatic check_multi(input string tag, input logic [4:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [63:0] exp_hilo);
    int l, bz;
    run_op(op, a, b, l, bz);
    check_eq({tag, "_lat"}, 64'(l), 64'd33);
    check_eq({tag, "_busy"}, 64'(bz), 64'd32);
    check_eq({tag, "_res"}, {C_hi, C}, exp_hilo);
    check_eq({tag, "_dbz"}, {63'd0, div_by_zero}, 64'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; A = 32'h0; B = 32'h0; ALUOp = 5'b00000;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", {63'd0, in_ready}, 64'd1);
    check_eq("rst_valid", {63'd0, out_valid}, 64'd0);
    check_eq("rst_c", {C_hi, C}, 64'd0);
    check_eq("rst_flags", {62'd0, Zero, div_by_zero}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    check_single("add_wrap", OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0);
    @(negedge clk);
    check_eq("pulse_once", {63'd0, out_valid}, 64'd0);
    check_eq("hold_c", {32'h0, C}, 64'h8000_0000);

    check_single("sra", OP_SRA, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1'b0);
    check_eq("b2b_ready", {63'd0, in_ready}, 64'd1);
    check_single("sltu", OP_SLTU, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    check_single("slt", OP_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0);
    check_single("sub", OP_SUB, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
    check_single("xor_eq", OP_XOR, 32'h0000_5A5A, 32'h0000_5A5A, 32'h0000_0000, 1'b1);
    check_single("nor", OP_NOR, 32'h0F0F_0000, 32'h0000_00F0, 32'hF0F0_FF0F, 1'b0);
    check_single("or", OP_OR, 32'h1200_0034, 32'h0056_0000, 32'h1256_0034, 1'b0);
    check_single("sll", OP_SLL, 32'h0000_0001, 32'h0000_003F, 32'h8000_0000, 1'b0);
    check_single("srl", OP_SRL, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1'b0);
    check_single("undef", 5'b10000, 32'h1111_1111, 32'hCAFE_BABE, 32'hCAFE_BABE, 1'b0);

    check_multi("mul_neg", OP_MUL, 32'hFFFF_FFFD, 32'h0000_0005, 64'hFFFF_FFFF_FFFF_FFF1);
    check_multi("mulu_max", OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    check_multi("mulu_eq", OP_MULU, 32'h0000_0003, 32'h0000_0003, 64'h0000_0000_0000_0009);
    check_eq("mulu_zero", {63'd0, Zero}, 64'd1);
    check_multi("div_pos_neg", OP_DIV, 32'h0000_0007, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD);
    check_multi("div_neg_pos", OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD);
    check_multi("div_min", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
    check_multi("divu", OP_DIVU, 32'h0000_0064, 32'h0000_0007, 64'h0000_0002_0000_000E);

    run_op(OP_DIVU, 32'h1234_5678, 32'h0000_0000, lat, busy);
    check_eq("dbz_lat", 64'(lat), 64'd1);
    check_eq("dbz_res", {C_hi, C}, 64'h1234_5678_FFFF_FFFF);
    check_eq("dbz_flag", {63'd0, div_by_zero}, 64'd1);
    check_eq("dbz_ready", {63'd0, in_ready}, 64'd1);
    run_op(OP_DIV, 32'hFFFF_FFF0, 32'h0000_0000, lat, busy);
    check_eq("dbz_s_res", {C_hi, C}, 64'hFFFF_FFF0_FFFF_FFFF);
    check_eq("dbz_s_flag", {63'd0, div_by_zero}, 64'd1);

    // Reset during iteration 10 of a MULU: the result must be dropped
    in_valid = 1'b1; ALUOp = OP_MULU; A = 32'h0000_1234; B = 32'h0000_5678;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("busy_pre_rst", {63'd0, in_ready}, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst_mid_ready", {63'd0, in_ready}, 64'd1);
    check_eq("rst_mid_valid", {63'd0, out_valid}, 64'd0);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    check_eq("rst_no_pulse", 64'(pulses), 64'd0);
    check_single("add_after_rst", OP_ADD, 32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
